seg7_display_ctrl: RTL and testbench



---
 rtl/seg7_display_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_seg7_display_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_display_ctrl.sv
// Seven-segment display controller: page selection (manual or auto-rotating),
// per-digit blinking, static per-digit segment outputs and a multiplexed
// scan bus with a blanking window at the start of every digit slot.
module seg7_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int NUM_PAGES  = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 50,
  parameter int AUTO_DWELL = 300,
  parameter int BLINK_HALF = 50,
  localparam int PW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clk_en,
  input  logic [NUM_PAGES*NUM_DIGITS*4-1:0] page_data,
  input  logic [PW-1:0]                     page_sel,
  input  logic                              auto_mode,
  input  logic [NUM_DIGITS-1:0]             blink_mask,
  output logic [PW-1:0]                     page_cur,
  output logic [NUM_DIGITS*7-1:0]           seg_static,
  output logic [6:0]                        seg_mux,
  output logic [NUM_DIGITS-1:0]             dig_en_n
);

  localparam int SW = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int DW = (AUTO_DWELL > 1) ? $clog2(AUTO_DWELL) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] LAST_PAGE  = PW'(NUM_PAGES - 1);
  localparam logic [PW:0]   NP_EXT     = (PW + 1)'(NUM_PAGES);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(AUTO_DWELL - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  // Active-low GFEDCBA hex font; anything unexpected shows blank.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [PW-1:0]           r_page_cur;
  logic                    r_auto_q;
  logic [DW-1:0]           r_dwell;
  logic [BW-1:0]           r_blink_cnt;
  logic                    r_blink_hidden;
  logic [SW-1:0]           r_slot;
  logic [IW-1:0]           r_idx;
  logic [NUM_DIGITS*7-1:0] r_seg_static;
  logic [6:0]              r_seg_mux;
  logic [NUM_DIGITS-1:0]   r_dig_en_n;

  logic [PW-1:0]           w_page_nxt;
  logic [DW-1:0]           w_dwell_nxt;
  logic [BW-1:0]           w_blink_cnt_nxt;
  logic                    w_blink_hidden_nxt;
  logic [SW-1:0]           w_slot_nxt;
  logic [IW-1:0]           w_idx_nxt;
  logic [NUM_DIGITS*7-1:0] w_seg_all;
  logic [NUM_DIGITS-1:0]   w_dig_nxt;
  logic                    w_mux_load;

  // Page selection: manual clamp or dwell-timed rotation; a mode flip only clears the dwell.
  always_comb begin
    w_page_nxt  = r_page_cur;
    w_dwell_nxt = r_dwell;
    if (auto_mode) begin
      if (auto_mode != r_auto_q) begin
        w_dwell_nxt = '0;
      end else if (clk_en) begin
        if (r_dwell == DWELL_LAST) begin
          w_dwell_nxt = '0;
          w_page_nxt  = (r_page_cur == LAST_PAGE) ? '0 : r_page_cur + PW'(1);
        end else begin
          w_dwell_nxt = r_dwell + DW'(1);
        end
      end else begin
        w_dwell_nxt = r_dwell;
      end
    end else begin
      w_dwell_nxt = '0;
      if ({1'b0, page_sel} >= NP_EXT) begin
        w_page_nxt = LAST_PAGE;
      end else begin
        w_page_nxt = page_sel;
      end
    end
  end

  // Blink timing; a page change restarts it in the visible phase.
  always_comb begin
    w_blink_cnt_nxt    = r_blink_cnt;
    w_blink_hidden_nxt = r_blink_hidden;
    if (w_page_nxt != r_page_cur) begin
      w_blink_cnt_nxt    = '0;
      w_blink_hidden_nxt = 1'b0;
    end else if (clk_en) begin
      if (r_blink_cnt == BLINK_LAST) begin
        w_blink_cnt_nxt    = '0;
        w_blink_hidden_nxt = ~r_blink_hidden;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + BW'(1);
      end
    end else begin
      w_blink_cnt_nxt = r_blink_cnt;
    end
  end

  // Scan slot/index stepping and the registered enables/segment load that follow them.
  always_comb begin
    w_slot_nxt = r_slot + SW'(1);
    w_idx_nxt  = r_idx;
    if (r_slot == SLOT_LAST) begin
      w_slot_nxt = '0;
      w_idx_nxt  = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    end else begin
      w_idx_nxt = r_idx;
    end
    w_mux_load = (w_slot_nxt < BLANK_END) || (w_slot_nxt == '0);
    w_dig_nxt  = '1;
    if (w_slot_nxt < BLANK_END) begin
      w_dig_nxt = '1;
    end else begin
      w_dig_nxt[w_idx_nxt] = 1'b0;
    end
  end

  // Decode every digit of the current page, blanking blinking digits in the hidden phase.
  always_comb begin
    w_seg_all = '1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (r_blink_hidden && blink_mask[d]) begin
        w_seg_all[d*7 +: 7] = 7'h7F;
      end else begin
        w_seg_all[d*7 +: 7] =
          hex_to_seg(page_data[(int'(r_page_cur) * NUM_DIGITS + d) * 4 +: 4]);
      end
    end
  end

  // Page, mode and blink state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_page_cur     <= '0;
      r_auto_q       <= auto_mode;
      r_dwell        <= '0;
      r_blink_cnt    <= '0;
      r_blink_hidden <= 1'b0;
    end else begin
      r_page_cur     <= w_page_nxt;
      r_auto_q       <= auto_mode;
      r_dwell        <= w_dwell_nxt;
      r_blink_cnt    <= w_blink_cnt_nxt;
      r_blink_hidden <= w_blink_hidden_nxt;
    end
  end

  // Scan counters and registered segment/enable outputs; seg_mux only reloads while blanked.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot       <= '0;
      r_idx        <= '0;
      r_seg_static <= '1;
      r_seg_mux    <= 7'h7F;
      r_dig_en_n   <= '1;
    end else begin
      r_slot       <= w_slot_nxt;
      r_idx        <= w_idx_nxt;
      r_seg_static <= w_seg_all;
      r_dig_en_n   <= w_dig_nxt;
      if (w_mux_load) begin
        r_seg_mux <= w_seg_all[int'(w_idx_nxt) * 7 +: 7];
      end else begin
        r_seg_mux <= r_seg_mux;
      end
    end
  end

  assign page_cur   = r_page_cur;
  assign seg_static = r_seg_static;
  assign seg_mux    = r_seg_mux;
  assign dig_en_n   = r_dig_en_n;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Bench for seg7_display_ctrl: a cycle-level behavioural model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_seg7_display_ctrl;

  localparam int ND = 4;
  localparam int NP = 3;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int AD = 3;
  localparam int BH = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clk_en = 1'b0;
  logic [NP*ND*4-1:0] page_data;
  logic [1:0]        page_sel = 2'd0;
  logic              auto_mode = 1'b0;
  logic [ND-1:0]     blink_mask = 4'b0000;
  logic [1:0]        page_cur;
  logic [ND*7-1:0]   seg_static;
  logic [6:0]        seg_mux;
  logic [ND-1:0]     dig_en_n;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_display_ctrl #(
    .NUM_DIGITS(ND), .NUM_PAGES(NP), .SCAN_DIV(SD),
    .BLANK_CYC(BC), .AUTO_DWELL(AD), .BLINK_HALF(BH)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .page_data(page_data),
    .page_sel(page_sel), .auto_mode(auto_mode), .blink_mask(blink_mask),
    .page_cur(page_cur), .seg_static(seg_static), .seg_mux(seg_mux),
    .dig_en_n(dig_en_n)
  );

  always #5 clk = ~clk;

  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: time since reset, tick counts and page number.
  bit            m_valid = 1'b0;
  int            m_cyc, m_page, m_auto_ticks, m_blink_ticks;
  logic          m_prev_auto;
  logic [ND*7-1:0] e_static;
  logic [6:0]    e_mux;
  logic [ND-1:0] e_dig;

  // Model update on each active edge, using the inputs present at that edge.
  always @(posedge clk) begin
    int slot, idx, newp;
    bit hid;
    if (rst) begin
      m_cyc = 0; m_page = 0; m_auto_ticks = 0; m_blink_ticks = 0;
      m_prev_auto = auto_mode;
      e_static = '1; e_mux = 7'h7F; e_dig = '1; m_valid = 1'b1;
    end else if (m_valid) begin
      hid = ((m_blink_ticks / BH) % 2) == 1;
      for (int d = 0; d < ND; d++)
        e_static[d*7 +: 7] = (hid && blink_mask[d]) ? 7'h7F
                                                    : font[page_data[(m_page*ND + d)*4 +: 4]];
      m_cyc++;
      slot = m_cyc % SD;
      idx  = (m_cyc / SD) % ND;
      if (slot < BC) e_mux = e_static[idx*7 +: 7];
      e_dig = (slot < BC) ? 4'b1111 : ~(4'b0001 << idx);
      newp = m_page;
      if (!auto_mode) begin
        newp = (int'(page_sel) >= NP) ? NP - 1 : int'(page_sel);
        m_auto_ticks = 0;
      end else if (auto_mode != m_prev_auto) begin
        m_auto_ticks = 0;
      end else if (clk_en) begin
        m_auto_ticks++;
        if (m_auto_ticks % AD == 0) newp = (m_page + 1) % NP;
      end
      m_prev_auto = auto_mode;
      if (newp != m_page) m_blink_ticks = 0;
      else if (clk_en) m_blink_ticks++;
      m_page = newp;
    end
  end

  logic [ND-1:0] p_dig = '1;
  logic [6:0]    p_mux = 7'h7F;

  // Compare process: model vs DUT and scan invariants, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("page_cur", 32'(page_cur), 32'(m_page));
      chk("seg_static", 32'(seg_static), 32'(e_static));
      chk("seg_mux", 32'(seg_mux), 32'(e_mux));
      chk("dig_en_n", 32'(dig_en_n), 32'(e_dig));
      chk("onehot_low", 32'($countones(~dig_en_n) <= 1), 32'd1);
      if (p_dig != 4'b1111 && dig_en_n == p_dig)
        chk("mux_stable", 32'(seg_mux), 32'(p_mux));
      p_dig = dig_en_n;
      p_mux = seg_mux;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    clk_en = 1'b1;
    cyc();
    clk_en = 1'b0;
  endtask

  initial begin
    logic [3:0] walk_exp [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    int   n_pages [9] = '{0, 0, 1, 1, 1, 2, 2, 2, 0};
    bit   hid_exp [6] = '{0, 1, 1, 0, 0, 1};
    logic [3:0] walk_got [$];
    logic [3:0] last;
    int   n_blank;
    bit   found;

    page_data = {16'h9A0F, 16'h5678, 16'h1234};
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_page", 32'(page_cur), 32'd0);
    chk("rst_static", 32'(seg_static), 32'h0FFF_FFFF);
    chk("rst_mux", 32'(seg_mux), 32'h7F);
    chk("rst_dig", 32'(dig_en_n), 32'hF);
    cyc();
    chk("c1_dig", 32'(dig_en_n), 32'hF);
    chk("c1_static", 32'(seg_static), 32'({7'h79, 7'h24, 7'h30, 7'h19}));
    cyc();
    chk("c2_dig", 32'(dig_en_n), 32'hE);
    chk("c2_mux", 32'(seg_mux), 32'h19);

    // Scan sweep
    last = dig_en_n; n_blank = 0;
    for (int i = 0; i < 32; i++) begin
      cyc();
      if (dig_en_n == 4'b1111) n_blank++;
      else if (dig_en_n != last) walk_got.push_back(dig_en_n);
      last = dig_en_n;
    end
    chk("sweep_blank_cycles", 32'(n_blank), 32'd8);
    chk("sweep_len", 32'(walk_got.size()), 32'd4);
    for (int i = 0; i < 4 && i < walk_got.size(); i++)
      chk("sweep_walk", 32'(walk_got[i]), 32'(walk_exp[i]));

    // Auto rotation; the enabling pulse coincides with the mode change
    auto_mode = 1'b1;
    pulse();
    chk("auto_first_ignored", 32'(page_cur), 32'd0);
    cyc();
    for (int k = 0; k < 9; k++) begin
      pulse();
      chk("auto_page", 32'(page_cur), 32'(n_pages[k]));
      cyc();
    end

    // Manual clamp
    auto_mode = 1'b0; page_sel = 2'd3;
    cyc();
    chk("clamp_page", 32'(page_cur), 32'd2);
    cyc();
    chk("clamp_static", 32'(seg_static), 32'({7'h10, 7'h08, 7'h40, 7'h0E}));
    page_sel = 2'd0;
    cyc(); cyc();

    // Blink on digits 0..1
    blink_mask = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      pulse();
      cyc();
      chk("blink_static", 32'(seg_static),
          hid_exp[k] ? 32'({7'h79, 7'h24, 7'h7F, 7'h7F}) : 32'({7'h79, 7'h24, 7'h30, 7'h19}));
    end
    page_sel = 2'd1;
    cyc();
    chk("blink_page", 32'(page_cur), 32'd1);
    cyc();
    chk("blink_restart", 32'(seg_static), 32'({7'h12, 7'h02, 7'h78, 7'h00}));

    // Reset mid-scan and mid-dwell
    auto_mode = 1'b1;
    cyc();
    pulse(); cyc();
    pulse(); cyc();
    found = 1'b0;
    for (int i = 0; i < 2*SD && !found; i++) begin
      if (m_cyc % SD == 2) found = 1'b1;
      else cyc();
    end
    chk("slot2_wait", 32'(found), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_page", 32'(page_cur), 32'd0);
    chk("mid_rst_static", 32'(seg_static), 32'h0FFF_FFFF);
    chk("mid_rst_mux", 32'(seg_mux), 32'h7F);
    chk("mid_rst_dig", 32'(dig_en_n), 32'hF);
    pulse(); cyc();
    pulse(); cyc();
    chk("post_rst_2", 32'(page_cur), 32'd0);
    pulse();
    chk("post_rst_3", 32'(page_cur), 32'd1);
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
